// File: rtl/sync_polarity_analyzer.sv
// Multi-channel sync polarity analyzer.
// Each channel measures the high and low run lengths of its sync input.
// A saturating vote with hysteresis decides the polarity: short high pulses
// mean positive sync. A channel whose sync stops toggling is marked inactive.
module sync_polarity_analyzer #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 20,
   parameter int VOTE_W      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 500000
) (
   input  logic              clk_50mhz_in,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] sync_in,
   output logic [NUM_CH-1:0] positive_polarity_out,
   output logic [NUM_CH-1:0] active_out,
   output logic [NUM_CH-1:0] polarity_change_out
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]  TO_VAL   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [VOTE_W-1:0] VOTE_MAX = '1;
   localparam logic [VOTE_W-1:0] VOTE_MID = VOTE_W'(1 << (VOTE_W - 1));

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_sr;
      logic                   sync_s;
      logic                   sync_d;
      logic                   edge_hit;
      logic                   fall;
      logic [CNT_W-1:0]       run_cnt;
      logic [CNT_W-1:0]       high_len;
      logic [CNT_W-1:0]       low_len;
      logic [CNT_W-1:0]       to_cnt;
      logic                   seen_edge;
      logic                   high_valid;
      logic                   low_valid;
      logic                   latched;
      logic                   compare;
      logic                   expire;
      logic [VOTE_W-1:0]      vote;
      logic [VOTE_W-1:0]      vote_nxt;
      logic                   pos;
      logic                   active;
      logic                   change;

      assign sync_s   = sync_sr[SYNC_STAGES-1];
      assign edge_hit = sync_s ^ sync_d;
      assign fall     = sync_d & ~sync_s;
      // An edge in the expiry cycle wins, so expiry never fires on an edge.
      assign expire   = ~edge_hit && (to_cnt == TO_LAST);
      assign compare  = latched & high_valid & low_valid;

      // Input synchroniser plus one-cycle delayed copy for edge detection.
      always_ff @(posedge clk_50mhz_in or negedge reset_n) begin
         if (!reset_n) begin
            sync_sr <= '0;
            sync_d  <= 1'b0;
         end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], sync_in[ch]};
            sync_d  <= sync_s;
         end
      end

      // Run-length counter; the finished level's length is captured on its closing edge.
      always_ff @(posedge clk_50mhz_in or negedge reset_n) begin
         if (!reset_n) begin
            run_cnt  <= '0;
            high_len <= '0;
            low_len  <= '0;
         end else if (edge_hit) begin
            run_cnt <= CNT_ONE;
            if (seen_edge) begin
               if (fall) high_len <= run_cnt;
               else      low_len  <= run_cnt;
            end
         end else if (run_cnt != CNT_MAX) begin
            run_cnt <= run_cnt + CNT_ONE;
         end
      end

      // Cycles since the last edge cycle (edge cycle itself counts as 0); parks at TIMEOUT.
      always_ff @(posedge clk_50mhz_in or negedge reset_n) begin
         if (!reset_n) begin
            to_cnt <= '0;
         end else if (edge_hit) begin
            to_cnt <= CNT_ONE;
         end else if (to_cnt != TO_VAL) begin
            to_cnt <= to_cnt + CNT_ONE;
         end
      end

      // Measurement validity flags and the compare request for the cycle after an edge.
      always_ff @(posedge clk_50mhz_in or negedge reset_n) begin
         if (!reset_n) begin
            seen_edge  <= 1'b0;
            high_valid <= 1'b0;
            low_valid  <= 1'b0;
            latched    <= 1'b0;
         end else begin
            latched <= edge_hit & seen_edge;
            if (expire) begin
               seen_edge  <= 1'b0;
               high_valid <= 1'b0;
               low_valid  <= 1'b0;
            end else if (edge_hit) begin
               seen_edge <= 1'b1;
               if (seen_edge) begin
                  if (fall) high_valid <= 1'b1;
                  else      low_valid  <= 1'b1;
               end
            end
         end
      end

      // Saturating vote: longer low than high means positive sync; ties vote negative.
      always_comb begin
         vote_nxt = vote;
         if (compare) begin
            if (low_len > high_len) begin
               if (vote != VOTE_MAX) vote_nxt = vote + 1'b1;
            end else begin
               if (vote != '0) vote_nxt = vote - 1'b1;
            end
         end
      end

      // Decision register: polarity only moves when the vote hits an end stop.
      always_ff @(posedge clk_50mhz_in or negedge reset_n) begin
         if (!reset_n) begin
            vote   <= VOTE_MID;
            pos    <= 1'b0;
            active <= 1'b0;
            change <= 1'b0;
         end else begin
            change <= 1'b0;
            if (expire) begin
               vote   <= VOTE_MID;
               active <= 1'b0;
            end else begin
               vote <= vote_nxt;
               if (compare) begin
                  if (vote_nxt == VOTE_MAX) begin
                     pos    <= 1'b1;
                     active <= 1'b1;
                     change <= ~pos;
                  end else if (vote_nxt == '0) begin
                     pos    <= 1'b0;
                     active <= 1'b1;
                     change <= pos;
                  end
               end
            end
         end
      end

      assign positive_polarity_out[ch] = pos;
      assign active_out[ch]            = active;
      assign polarity_change_out[ch]   = change;
   end

endmodule

// File: tb/tb_sync_polarity_analyzer.sv
// Directed bench for sync_polarity_analyzer: polarity lock, hysteresis,
// timeout and reset behaviour with hand-derived cycle positions.
// Inputs change on the falling clock edge; a change made there becomes an
// edge cycle two rising edges later and its decision is visible 4 falling
// edges after the change.
module tb_sync_polarity_analyzer;

   localparam int NUM_CH  = 2;
   localparam int TIMEOUT = 1000;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NUM_CH-1:0] sync_in;
   logic [NUM_CH-1:0] pos;
   logic [NUM_CH-1:0] act;
   logic [NUM_CH-1:0] chg;

   int n_checks = 0;
   int n_errors = 0;
   int chg_cnt0 = 0;
   int chg_cnt1 = 0;

   sync_polarity_analyzer #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (16),
      .VOTE_W      (4),
      .SYNC_STAGES (2),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk_50mhz_in          (clk),
      .reset_n               (reset_n),
      .sync_in               (sync_in),
      .positive_polarity_out (pos),
      .active_out            (act),
      .polarity_change_out   (chg)
   );

   always #10 clk = ~clk;

   // Count change pulses per channel.
   always @(negedge clk) begin
      if (chg[0]) chg_cnt0 = chg_cnt0 + 1;
      if (chg[1]) chg_cnt1 = chg_cnt1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ch0 at 5 high / 60 low from idle-low: compares start at edge 3,
   // seven up-votes from 8 lock positive on edge 9.
   task automatic ch0_positive();
      for (int i = 0; i < 4; i++) begin
         sync_in[0] = 1'b1; tick(5);
         sync_in[0] = 1'b0; tick(60);
      end
      sync_in[0] = 1'b1;
      tick(3);
      chk("pos0_before_lock", pos[0], 1'b0);
      chk("act0_before_lock", act[0], 1'b0);
      tick(1);
      chk("pos0_lock", pos[0], 1'b1);
      chk("act0_lock", act[0], 1'b1);
      chk("chg0_lock_pulse", chg[0], 1'b1);
      chk("pos1_idle", pos[1], 1'b0);
      chk("act1_idle", act[1], 1'b0);
      tick(1);
      chk("chg0_pulse_end", chg[0], 1'b0);
      tick(3);
   endtask

   initial begin
      reset_n = 1'b0;
      sync_in = '0;
      tick(2);
      for (int i = 0; i < 6; i++) begin
         sync_in = ~sync_in;
         tick(1);
      end
      chk("rst_pos", {30'd0, pos}, 32'd0);
      chk("rst_act", {30'd0, act}, 32'd0);
      chk("rst_chg", {30'd0, chg}, 32'd0);
      sync_in = '0;
      tick(3);
      reset_n = 1'b1;
      tick(10);

      ch0_positive();
      chk("chg0_count_a", chg_cnt0, 1);

      // Asynchronous reset in the middle of a low level.
      sync_in[0] = 1'b0;
      tick(10);
      chk("pos0_before_rst", pos[0], 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_pos0", pos[0], 1'b0);
      chk("midrst_act0", act[0], 1'b0);
      chk("midrst_chg0", chg[0], 1'b0);
      tick(3);
      sync_in = '0;
      reset_n = 1'b1;
      tick(10);
      chk("chg0_count_b", chg_cnt0, 1);

      ch0_positive();
      chk("chg0_count_c", chg_cnt0, 2);

      // Hysteresis at 30/30: the first two compares still see a 60-cycle low,
      // equal-length down-votes start at 30/30 edge 3, vote reaches 0 at edge 17.
      sync_in[0] = 1'b0;
      tick(60);
      for (int k = 1; k <= 16; k++) begin
         sync_in[0] = k[0];
         if (k == 16) begin
            tick(4);
            chk("hyst_hold_14", pos[0], 1'b1);
            tick(26);
         end else begin
            tick(30);
         end
      end
      sync_in[0] = 1'b1;
      tick(3);
      chk("hyst_pre_fall", pos[0], 1'b1);
      tick(1);
      chk("hyst_fall_pos0", pos[0], 1'b0);
      chk("hyst_fall_chg0", chg[0], 1'b1);
      tick(26);
      chk("chg0_count_d", chg_cnt0, 3);

      // Relock positive, ending on a rising edge that is then held.
      for (int i = 0; i < 9; i++) begin
         sync_in[0] = 1'b0; tick(60);
         sync_in[0] = 1'b1; tick(5);
      end
      sync_in[0] = 1'b0; tick(60);
      sync_in[0] = 1'b1;
      tick(4);
      chk("relock_pos0", pos[0], 1'b1);
      chk("relock_act0", act[0], 1'b1);
      chk("chg0_count_e", chg_cnt0, 4);
      tick(TIMEOUT + 1 - 4);
      chk("to_act0_before", act[0], 1'b1);
      tick(1);
      chk("to_act0_after", act[0], 1'b0);
      chk("to_pos0_hold", pos[0], 1'b1);

      // Resume with 60 high / 5 low from the midpoint vote: 8 down-votes, edges 3..10.
      for (int e = 1; e <= 9; e++) begin
         sync_in[0] = ~e[0];
         if (e == 9) begin
            tick(4);
            chk("resume_act0_e9", act[0], 1'b0);
            chk("resume_pos0_e9", pos[0], 1'b1);
            tick(1);
         end else begin
            tick(e[0] ? 5 : 60);
         end
      end
      sync_in[0] = 1'b1;
      tick(3);
      chk("resume_pos0_pre", pos[0], 1'b1);
      tick(1);
      chk("resume_pos0", pos[0], 1'b0);
      chk("resume_act0", act[0], 1'b1);
      chk("resume_chg0", chg[0], 1'b1);
      tick(56);
      chk("chg0_count_f", chg_cnt0, 5);

      // ch1 at 60 high / 5 low: negative, active after the 10th edge.
      for (int e = 1; e <= 9; e++) begin
         sync_in[1] = e[0];
         tick(e[0] ? 60 : 5);
      end
      sync_in[1] = 1'b0;
      tick(3);
      chk("act1_pre", act[1], 1'b0);
      tick(1);
      chk("act1_neg", act[1], 1'b1);
      chk("pos1_neg", pos[1], 1'b0);
      chk("chg1_neg", chg[1], 1'b0);
      tick(10);
      chk("chg1_count", chg_cnt1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
